mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 177 +++++++++++++++++
 tb/tb_mdu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// HI/LO multiply-divide unit: single-edge MULT/MULTU/MTHI/MTLO plus a 32-cycle
// radix-2 restoring divider that is only built when MDU_DIV_EN is defined.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mdu #(
    parameter int W = `WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic [2:0]   mdu_op,
    input  logic         start,
    input  logic         flush,
    output logic         busy,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic [W-1:0]   hi_r, lo_r, hi_nxt_s, lo_nxt_s;
    logic           idle_s, accept_s, mul_sgn_s;
    logic [2*W-1:0] mul_a_s, mul_b_s, prod_s;
    logic           div_wr_s;
    logic [W-1:0]   div_hi_s, div_lo_s;

    assign accept_s  = start & ~flush & idle_s;
    assign mul_sgn_s = (mdu_op == OP_MULT);
    // Sign- or zero-extend to 2W so one multiplier serves both MULT and MULTU.
    assign mul_a_s   = {{W{mul_sgn_s & op1[W-1]}}, op1};
    assign mul_b_s   = {{W{mul_sgn_s & op2[W-1]}}, op2};
    assign prod_s    = mul_a_s * mul_b_s;

`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;

    typedef enum logic [0:0] {IDLE = 1'b0, DIV = 1'b1} state_t;

    state_t       state_r, state_nxt_s;
    logic         busy_r;
    logic [4:0]   cnt_r;
    logic [W-1:0] rem_r, quo_r, dvs_r, rem_nxt_s, quo_nxt_s;
    logic         neg_q_r, neg_r_r, dz_r;
    logic         div_req_s, div_sgn_s, last_s;
    logic [W:0]   shift_s, diff_s;

    function automatic logic [W-1:0] negate(input logic [W-1:0] x);
        negate = ~x + {{(W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        mag = x[W-1] ? negate(x) : x;
    endfunction

    assign idle_s    = (state_r == IDLE);
    assign div_req_s = accept_s & ((mdu_op == OP_DIV) | (mdu_op == OP_DIVU));
    assign div_sgn_s = (mdu_op == OP_DIV);
    assign last_s    = (cnt_r == 5'd31);

    // The quotient register doubles as the dividend shifter: each step moves its MSB into rem.
    assign shift_s   = {rem_r, quo_r[W-1]};
    assign diff_s    = shift_s - {1'b0, dvs_r};
    assign rem_nxt_s = diff_s[W] ? shift_s[W-1:0] : diff_s[W-1:0];
    assign quo_nxt_s = {quo_r[W-2:0], ~diff_s[W]};

    // Divide by zero keeps the remainder fixup: negating |op1| restores op1 itself.
    assign div_wr_s  = (state_r == DIV) & ~flush & last_s;
    assign div_lo_s  = dz_r ? {W{1'b1}} : (neg_q_r ? negate(quo_nxt_s) : quo_nxt_s);
    assign div_hi_s  = neg_r_r ? negate(rem_nxt_s) : rem_nxt_s;
    assign busy      = busy_r;

    // State register and registered busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == DIV);
        end
    end

    // Next-state logic; flush always wins over the final iteration.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (div_req_s) state_nxt_s = DIV;
                else           state_nxt_s = IDLE;
            end
            DIV: begin
                if (flush || last_s) state_nxt_s = IDLE;
                else                 state_nxt_s = DIV;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Divider operand latch and iteration datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= 5'd0;
            rem_r   <= {W{1'b0}};
            quo_r   <= {W{1'b0}};
            dvs_r   <= {W{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            dz_r    <= 1'b0;
        end else if (div_req_s) begin
            cnt_r   <= 5'd0;
            rem_r   <= {W{1'b0}};
            quo_r   <= div_sgn_s ? mag(op1) : op1;
            dvs_r   <= div_sgn_s ? mag(op2) : op2;
            neg_q_r <= div_sgn_s & (op1[W-1] ^ op2[W-1]);
            neg_r_r <= div_sgn_s & op1[W-1];
            dz_r    <= (op2 == {W{1'b0}});
        end else if ((state_r == DIV) && !flush) begin
            cnt_r   <= cnt_r + 5'd1;
            rem_r   <= rem_nxt_s;
            quo_r   <= quo_nxt_s;
        end
    end
`else
    assign idle_s   = 1'b1;
    assign div_wr_s = 1'b0;
    assign div_hi_s = {W{1'b0}};
    assign div_lo_s = {W{1'b0}};
    assign busy     = 1'b0;
`endif

    // Next HI/LO values: divider completion or an accepted single-edge operation.
    always_comb begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        if (div_wr_s) begin
            hi_nxt_s = div_hi_s;
            lo_nxt_s = div_lo_s;
        end else if (accept_s) begin
            case (mdu_op)
                OP_MULT, OP_MULTU: begin
                    hi_nxt_s = prod_s[2*W-1:W];
                    lo_nxt_s = prod_s[W-1:0];
                end
                OP_MTHI: hi_nxt_s = op1;
                OP_MTLO: lo_nxt_s = op1;
                default: begin
                    hi_nxt_s = hi_r;
                    lo_nxt_s = lo_r;
                end
            endcase
        end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
        end
    end

    // HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= {W{1'b0}};
            lo_r <= {W{1'b0}};
        end else begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
        end
    end

    assign hi = hi_r;
    assign lo = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes hand-computed HI/LO/busy expectations,
// a negedge monitor pops and compares them. Division expectations depend on MDU_DIV_EN.
module tb_mdu;
    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam logic [2:0] NOP   = 3'b000;
    localparam logic [2:0] MULT  = 3'b001;
    localparam logic [2:0] MULTU = 3'b010;
    localparam logic [2:0] DIV   = 3'b011;
    localparam logic [2:0] DIVU  = 3'b100;
    localparam logic [2:0] MTHI  = 3'b101;
    localparam logic [2:0] MTLO  = 3'b110;
    localparam logic [2:0] RSVD  = 3'b111;

    logic         clk, rst, start, flush, busy;
    logic [2:0]   mdu_op;
    logic [W-1:0] op1, op2, hi, lo;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         busy;
    } exp_t;

    exp_t         sb_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] mh, ml;

    mdu #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .op1    (op1),
        .op2    (op2),
        .mdu_op (mdu_op),
        .start  (start),
        .flush  (flush),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Record an expectation and advance the reference HI/LO model.
    task automatic expect_st(input string name, input logic [W-1:0] h, input logic [W-1:0] l,
                             input logic b);
        exp_t e;
        e.name = name;
        e.hi   = h;
        e.lo   = l;
        e.busy = b;
        sb_q.push_back(e);
        mh = h;
        ml = l;
    endtask

    // Monitor: shortly after every falling edge, drain and compare pending expectations.
    always @(negedge clk) begin
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.name, " hi"}, hi, e.hi);
            check({e.name, " lo"}, lo, e.lo);
            check({e.name, " busy"}, {31'b0, busy}, {31'b0, e.busy});
        end
    end

    // Present one request for a single rising edge; returns on the following falling edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic go, input logic fl);
        mdu_op = op;
        op1    = a;
        op2    = b;
        start  = go;
        flush  = fl;
        @(negedge clk);
        start  = 1'b0;
        flush  = 1'b0;
        mdu_op = NOP;
    endtask

    task automatic div_run(input string name, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] q, input logic [W-1:0] r);
        int n;
        issue(op, a, b, 1'b1, 1'b0);
        n = busy ? 1 : 0;
        while (busy && n < 40) begin
            @(negedge clk);
            if (busy) n++;
        end
        check({name, " busy cycles"}, n, DIV_EN ? 32 : 0);
        expect_st(name, DIV_EN ? r : mh, DIV_EN ? q : ml, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; mdu_op = NOP;
        op1 = 32'h0; op2 = 32'h0; mh = 32'h0; ml = 32'h0;
        @(negedge clk);
        expect_st("reset", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        issue(MULT, 32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b0);
        expect_st("mult neg", 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        issue(MULTU, 32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b0);
        expect_st("multu", 32'h00000002, 32'hFFFFFFFA, 1'b0);
        issue(MULT, 32'h12345678, 32'h00000010, 1'b1, 1'b0);
        expect_st("mult pos", 32'h00000001, 32'h23456780, 1'b0);
        issue(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        expect_st("mult m1", 32'h00000000, 32'h00000001, 1'b0);
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        expect_st("multu max", 32'hFFFFFFFE, 32'h00000001, 1'b0);
        issue(MTHI, 32'h00001111, 32'h0, 1'b1, 1'b0);
        expect_st("mthi", 32'h00001111, 32'h00000001, 1'b0);
        issue(MTLO, 32'h00002222, 32'h0, 1'b1, 1'b0);
        expect_st("mtlo", 32'h00001111, 32'h00002222, 1'b0);
        issue(NOP, 32'h55555555, 32'h55555555, 1'b1, 1'b0);
        expect_st("nop", mh, ml, 1'b0);
        issue(RSVD, 32'h55555555, 32'h55555555, 1'b1, 1'b0);
        expect_st("reserved", mh, ml, 1'b0);
        issue(MTHI, 32'h55555555, 32'h0, 1'b0, 1'b0);
        expect_st("no start", mh, ml, 1'b0);
        issue(MULT, 32'h55555555, 32'h00000003, 1'b1, 1'b1);
        expect_st("flush cancel", mh, ml, 1'b0);

        div_run("div -7/2", DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF);
        div_run("divu 100/0", DIVU, 32'd100, 32'h0, 32'hFFFFFFFF, 32'd100);
        div_run("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
        div_run("div 7/-2", DIV, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
        div_run("divu 1000/7", DIVU, 32'd1000, 32'd7, 32'd142, 32'd6);
        div_run("div -8/0", DIV, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF8);

        // Abort a division on its tenth busy cycle.
        issue(DIVU, 32'd1000, 32'd7, 1'b1, 1'b0);
        check("flush busy start", {31'b0, busy}, {31'b0, DIV_EN});
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        expect_st("flush abort", mh, ml, 1'b0);
        issue(MTLO, 32'd5, 32'h0, 1'b1, 1'b0);
        expect_st("mtlo after flush", mh, 32'd5, 1'b0);

        // A request while busy is dropped.
        issue(DIVU, 32'd1000, 32'd7, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        issue(MTHI, 32'h00001234, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        expect_st("busy ignores mthi", DIV_EN ? 32'd6 : 32'h00001234, DIV_EN ? 32'd142 : ml, 1'b0);

        // Asynchronous reset mid-division, then normal operation resumes.
        issue(DIVU, 32'd1000, 32'd7, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        expect_st("reset mid-div", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        issue(MTHI, 32'h0000ABCD, 32'h0, 1'b1, 1'b0);
        expect_st("mthi after reset", 32'h0000ABCD, 32'h0, 1'b0);
        div_run("divu after reset", DIVU, 32'd9, 32'd4, 32'd2, 32'd1);

        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
